mac_lane_array: RTL and testbench

//  Parametrised successor to the single-DSP MulAdder: LANES signed multiply-accumulate lanes sharing one activation stream.

---
 rtl/mac_lane_array_pkg.sv | 10 +
 rtl/mac_lane_array_if.sv | 20 ++
 rtl/mac_lane_array_lane.sv | 56 +++++
 rtl/mac_lane_array.sv | 97 +++++++++
 tb/tb_mac_lane_array.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_lane_array_pkg.sv
// mac_lane_array_pkg: shared FSM encoding and default widths for the MAC lane array
package mac_lane_array_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, HOLD = 2'd3} state_t;
  localparam int LANES_D = 4;
  localparam int A_W_D = 16;
  localparam int B_W_D = 16;
  localparam int ACC_W_D = 48;
  localparam int OUT_W_D = 36;
  localparam int LEN_W_D = 10;
endpackage

// File: rtl/mac_lane_array_if.sv
// mac_lane_array_if: input beat stream and held result stream of the MAC lane array
interface mac_lane_array_if
  import mac_lane_array_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int A_W   = A_W_D,
  parameter int B_W   = B_W_D,
  parameter int OUT_W = OUT_W_D
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*A_W-1:0]   in_a;
  logic [B_W-1:0]         in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_data, out_sat);
  modport slave  (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/mac_lane_array_lane.sv
// mac_lane: one lane's operand/product/accumulate pipeline plus saturating or truncating output register
module mac_lane #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 48,
  parameter int OUT_W = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fire,
  input  logic                    acc_en,
  input  logic                    start,
  input  logic                    load,
  input  logic                    sub,
  input  logic                    sat_en,
  input  logic signed [OUT_W-1:0] bias,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat
);
  logic signed [A_W-1:0]     a_q;
  logic signed [B_W-1:0]     b_q;
  logic signed [A_W+B_W-1:0] p;
  logic signed [ACC_W-1:0]   acc, p_x;
  logic [ACC_W-OUT_W:0]      hi;
  logic                      ovf;
  logic [OUT_W-1:0]          res;
  assign p_x = ACC_W'(p);
  assign hi  = acc[ACC_W-1:OUT_W-1];
  // the value fits OUT_W only when every bit above the output sign bit copies it
  assign ovf = sat_en && !(&hi || !(|hi));
  assign res = ovf ? (acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}) : acc[OUT_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p <= '0;
      acc <= '0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      if (fire) begin
        a_q <= a;
        b_q <= b;
      end
      p <= (A_W+B_W)'(a_q) * (A_W+B_W)'(b_q);
      if (start) acc <= ACC_W'(bias);
      else if (acc_en) acc <= sub ? acc - p_x : acc + p_x;
      if (load) begin
        out_data <= res;
        out_sat <= ovf;
      end
    end
  end
endmodule

// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES signed MAC lanes over a shared activation stream, with bias preload,
// add/subtract mode, optional saturation, and a held result handshake.
module mac_lane_array
  import mac_lane_array_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int A_W   = A_W_D,
  parameter int B_W   = B_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int LEN_W = LEN_W_D
) (
  input  logic                   CLK,
  input  logic                   SCLR,
  input  logic                   cfg_start,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_sub,
  input  logic                   cfg_sat,
  input  logic [LANES*OUT_W-1:0] bias,
  output logic                   busy,
  mac_lane_array_if.slave        s
);
  state_t                 state;
  logic [LEN_W-1:0]       len_q, cnt;
  logic                   sub_q, sat_q, v1, v2, v3, fire, start, load;
  logic [LANES*OUT_W-1:0] od;
  logic [LANES-1:0]       os;
  assign fire  = s.in_valid && s.in_ready;
  assign start = state == IDLE && cfg_start && cfg_len != '0;
  // v3 marks the cycle the last accumulate lands, so the output loads one edge later
  assign load  = state == FLUSH && !v1 && !v2 && !v3;
  assign s.out_data = od;
  assign s.out_sat  = os;
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state <= IDLE;
      len_q <= '0;
      cnt <= '0;
      sub_q <= 1'b0;
      sat_q <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      busy <= 1'b0;
      s.in_ready <= 1'b0;
      s.out_valid <= 1'b0;
    end else begin
      v1 <= fire;
      v2 <= v1;
      v3 <= v2;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          len_q <= cfg_len;
          sub_q <= cfg_sub;
          sat_q <= cfg_sat;
          cnt <= '0;
          busy <= 1'b1;
          s.in_ready <= 1'b1;
        end
        RUN: if (fire) begin
          cnt <= cnt + LEN_W'(1);
          if (cnt == len_q - LEN_W'(1)) begin
            state <= FLUSH;
            s.in_ready <= 1'b0;
          end
        end
        FLUSH: if (load) begin
          state <= HOLD;
          s.out_valid <= 1'b1;
        end
        HOLD: if (s.out_ready) begin
          state <= IDLE;
          busy <= 1'b0;
          s.out_valid <= 1'b0;
        end
      endcase
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
      .clk(CLK),
      .rst(SCLR),
      .fire(fire),
      .acc_en(v2),
      .start(start),
      .load(load),
      .sub(sub_q),
      .sat_en(sat_q),
      .bias(bias[k*OUT_W +: OUT_W]),
      .a(s.in_a[k*A_W +: A_W]),
      .b(s.in_b),
      .out_data(od[k*OUT_W +: OUT_W]),
      .out_sat(os[k])
    );
  end
endmodule

// File: tb/tb_mac_lane_array.sv
// tb_mac_lane_array: randomized and directed transactions checked by a queue scoreboard
// against a plain-arithmetic dot-product model.
module tb_mac_lane_array;
  localparam int LANES = 4, A_W = 16, B_W = 16, ACC_W = 48, OUT_W = 36, LEN_W = 10;
  localparam longint MAXO = 64'sd34359738367;
  localparam longint MINO = -64'sd34359738368;
  typedef struct {
    logic [LANES*OUT_W-1:0] d;
    logic [LANES-1:0]       s;
  } exp_t;
  logic CLK = 1'b0, SCLR = 1'b1, cfg_start = 1'b0, cfg_sub = 1'b0, cfg_sat = 1'b0, busy;
  logic [LEN_W-1:0]       cfg_len = '0;
  logic [LANES*OUT_W-1:0] bias = '0;
  int total = 0, bad = 0, cyc = 0, last_hs = 0;
  exp_t exp_q[$];
  logic [LANES*A_W-1:0] qa[$];
  logic [B_W-1:0]       qb[$];
  longint bv[LANES];

  mac_lane_array_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) io ();
  mac_lane_array #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .SCLR(SCLR), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_sub(cfg_sub),
    .cfg_sat(cfg_sat), .bias(bias), .busy(busy), .s(io)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (io.in_valid && io.in_ready) last_hs <= cyc + 1;
  end

  function automatic void chk(string n, logic [LANES*OUT_W-1:0] got, logic [LANES*OUT_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endfunction

  // scoreboard monitor: pops on the first cycle of each held result, then checks it stays put
  initial begin
    bit have = 0, stray = 0;
    exp_t cur;
    forever begin
      @(negedge CLK);
      if (!SCLR && io.out_valid) begin
        if (!have) begin
          have = 1;
          if (exp_q.size() == 0) begin
            stray = 1;
            total++;
            bad++;
            $display("FAIL unexpected_out got=%h want=none", io.out_data);
          end else begin
            stray = 0;
            cur = exp_q.pop_front();
            chk("latency", (LANES*OUT_W)'(cyc - last_hs), (LANES*OUT_W)'(4));
            chk("out_data", io.out_data, cur.d);
            chk("out_sat", (LANES*OUT_W)'(io.out_sat), (LANES*OUT_W)'(cur.s));
          end
        end else if (!stray) begin
          chk("hold_data", io.out_data, cur.d);
          chk("hold_sat", (LANES*OUT_W)'(io.out_sat), (LANES*OUT_W)'(cur.s));
        end
        if (io.out_ready) have = 0;
      end
    end
  end

  task automatic push_model(input int len, input bit sub, input bit sat);
    exp_t e;
    for (int k = 0; k < LANES; k++) begin
      longint acc = bv[k];
      for (int i = 0; i < len; i++) begin
        logic [LANES*A_W-1:0] w = qa[i];
        logic [B_W-1:0] bb = qb[i];
        longint prod = longint'($signed(w[k*A_W +: A_W])) * longint'($signed(bb));
        acc = sub ? acc - prod : acc + prod;
        acc = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
      end
      e.s[k] = sat && (acc > MAXO || acc < MINO);
      if (sat && acc > MAXO) acc = MAXO;
      if (sat && acc < MINO) acc = MINO;
      e.d[k*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input int len, input bit sub, input bit sat, input bit gaps,
                         input int stall, input bit pulses, input int abort_after);
    int i = 0, g = 0;
    bit hs;
    @(posedge CLK); #1;
    cfg_start = 1; cfg_len = LEN_W'(len); cfg_sub = sub; cfg_sat = sat;
    for (int k = 0; k < LANES; k++) bias[k*OUT_W +: OUT_W] = bv[k][OUT_W-1:0];
    @(posedge CLK); #1;
    cfg_start = 0;
    while (i < len && g < len * 8 + 40 && !(abort_after > 0 && i == abort_after)) begin
      g++;
      io.in_valid = !(gaps && $urandom_range(0, 2) == 0);
      io.in_a = qa[i];
      io.in_b = qb[i];
      cfg_start = pulses && $urandom_range(0, 3) == 0;
      cfg_len = LEN_W'(len + 1);
      cfg_sub = ~sub;
      @(negedge CLK);
      hs = io.in_valid && io.in_ready;
      @(posedge CLK); #1;
      if (hs) i++;
    end
    io.in_valid = 0;
    cfg_start = 0;
    if (abort_after > 0) begin
      SCLR = 1;
      repeat (2) @(posedge CLK);
      #1 SCLR = 0;
      @(negedge CLK);
      chk("abort_out_valid", (LANES*OUT_W)'(io.out_valid), '0);
      chk("abort_in_ready", (LANES*OUT_W)'(io.in_ready), '0);
      chk("abort_busy", (LANES*OUT_W)'(busy), '0);
      repeat (20) @(posedge CLK);
      return;
    end
    if (i < len) begin
      total++; bad++;
      $display("FAIL beat_timeout got=%0d want=%0d", i, len);
      return;
    end
    push_model(len, sub, sat);
    g = 0;
    while (!io.out_valid && g < 20) begin
      cfg_start = pulses;
      @(posedge CLK); #1;
      g++;
    end
    repeat (stall) begin
      cfg_start = pulses;
      @(posedge CLK); #1;
    end
    io.out_ready = 1;
    g = 0;
    do begin
      cfg_start = pulses;
      @(negedge CLK);
      hs = io.out_valid && io.out_ready;
      @(posedge CLK); #1;
      g++;
    end while (!hs && g < 30);
    cfg_start = 0;
    io.out_ready = 0;
    if (!hs) begin
      total++; bad++;
      $display("FAIL out_timeout got=0 want=1");
    end
    @(negedge CLK);
    chk("idle_busy", (LANES*OUT_W)'(busy), '0);
    chk("idle_in_ready", (LANES*OUT_W)'(io.in_ready), '0);
  endtask

  task automatic fill_const(input int len, input int av, input int bval, input longint bs, input bit per_lane);
    logic [LANES*A_W-1:0] w;
    qa.delete();
    qb.delete();
    for (int k = 0; k < LANES; k++) begin
      bv[k] = bs;
      w[k*A_W +: A_W] = A_W'(per_lane ? k + 1 : av);
    end
    for (int i = 0; i < len; i++) begin
      qa.push_back(w);
      qb.push_back(B_W'(bval));
    end
  endtask

  initial begin
    io.in_valid = 0; io.in_a = '0; io.in_b = '0; io.out_ready = 0;
    repeat (3) @(posedge CLK);
    #1 SCLR = 0;
    @(negedge CLK);
    chk("rst_out_valid", (LANES*OUT_W)'(io.out_valid), '0);
    chk("rst_in_ready", (LANES*OUT_W)'(io.in_ready), '0);
    chk("rst_busy", (LANES*OUT_W)'(busy), '0);
    chk("rst_out_data", io.out_data, '0);
    chk("rst_out_sat", (LANES*OUT_W)'(io.out_sat), '0);
    fill_const(5, 3, 4, 0, 0);
    run_txn(5, 0, 0, 0, 0, 0, 2);
    fill_const(1, -10, -5, 0, 0);
    run_txn(1, 0, 0, 0, 0, 0, 0);
    fill_const(4, 0, 3, -20, 1);
    run_txn(4, 0, 0, 0, 0, 0, 0);
    fill_const(2, 7, 5, 100, 0);
    run_txn(2, 1, 0, 0, 0, 0, 0);
    fill_const(128, 32767, 32767, 0, 0);
    run_txn(128, 0, 1, 0, 0, 0, 0);
    run_txn(128, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 25; t++) begin
      int len = (t % 6 == 5) ? int'($urandom_range(30, 60)) : int'($urandom_range(1, 12));
      qa.delete();
      qb.delete();
      for (int k = 0; k < LANES; k++) begin
        longint r = {$urandom, $urandom};
        bv[k] = (r <<< (64 - OUT_W)) >>> (64 - OUT_W);
      end
      for (int i = 0; i < len; i++) begin
        logic [LANES*A_W-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*A_W +: A_W] = A_W'($urandom);
        qa.push_back(w);
        qb.push_back(B_W'($urandom));
      end
      run_txn(len, 1'($urandom), 1'($urandom), 1, (t % 3 == 0) ? 5 : int'($urandom_range(0, 2)), 1'($urandom), 0);
    end
    repeat (5) @(posedge CLK);
    chk("queue_empty", (LANES*OUT_W)'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
